// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Time-multiplexed scan controller for an NDIG-digit common-anode
//            seven-segment display. Holds a hex value and a decimal-point
//            bit per digit, scans digits round-robin with an optional
//            anti-ghosting blank phase, and drives active-low pins.
// Options  : SEG7_LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//            (any digit k>0 whose value and all higher digits are 0) are
//            shown dark; their decimal point still lights if set.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int AW       = 2,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              wr_dp,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [2**AW-1:0]  an,
    output logic [AW-1:0]     digit_idx,
    output logic              frame_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ndig  = 2**AW;
    localparam int c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Last count of a slot, and last count of the blank phase. The blank
    // constant is unused when BLANK=0 because the blank state is skipped.
    localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(PRESCALE - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = (BLANK > 0) ? c_cnt_w'(BLANK - 1) : '0;
    localparam logic               c_blank_en   = (BLANK > 0);
    localparam logic [AW-1:0]      c_idx_last   = '1;

    // Scan state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_blank = 2'd1;
    localparam logic [1:0] c_st_show  = 2'd2;

    // ------------------------------------------------------------------------
    // Hex to active-low segment pattern, bit 6 = a ... bit 0 = g
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001111;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b1100000;
            4'hC:    pat = 7'b0110001;
            4'hD:    pat = 7'b1000010;
            4'hE:    pat = 7'b0110000;
            default: pat = 7'b0111000;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [3:0]         r_digit [c_ndig];
    logic [c_ndig-1:0]  r_dp_reg;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [AW-1:0]      r_idx;

    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [AW-1:0]      w_idx_nxt;

    logic [c_ndig-1:0]  w_onehot;
    logic               w_suppress;

    logic [6:0]         w_seg_nxt;
    logic               w_dp_nxt;
    logic [c_ndig-1:0]  w_an_nxt;
    logic               w_tick_nxt;

    // ------------------------------------------------------------------------
    // Digit register file: writes accepted every cycle, reset wins over write
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < c_ndig; k++) begin
                r_digit[k] <= 4'd0;
            end
            r_dp_reg <= '0;
        end else if (wr_en) begin
            r_digit[wr_addr]  <= wr_data;
            r_dp_reg[wr_addr] <= wr_dp;
        end
    end

    // ------------------------------------------------------------------------
    // Scan state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Scan next-state: the slot counter runs straight through the blank and
    // show phases so a slot is always exactly PRESCALE cycles long
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (!en) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_blank_en ? c_st_blank : c_st_show;
                end
                c_st_blank: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_blank_last) begin
                        w_state_nxt = c_st_show;
                    end
                end
                c_st_show: begin
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = c_blank_en ? c_st_blank : c_st_show;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Anode select for the current slot (active-high here, inverted on output)
    assign w_onehot = {{(c_ndig-1){1'b0}}, 1'b1} << r_idx;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [c_ndig-1:0] w_lz;

    // Leading-zero flags: digit k is a leading zero when it and every
    // more-significant digit hold 0
    always_comb begin
        logic v_acc;
        v_acc = 1'b1;
        w_lz  = '0;
        for (int k = c_ndig - 1; k >= 0; k--) begin
            v_acc   = v_acc && (r_digit[k] == 4'd0);
            w_lz[k] = v_acc;
        end
    end

    // Digit 0 always shows, so a value of zero still reads as "0"
    assign w_suppress = (r_idx != '0) && w_lz[r_idx];
`else
    assign w_suppress = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Pin values for the next cycle; dropping en darkens the pins at once
    // ------------------------------------------------------------------------
    always_comb begin
        w_seg_nxt  = 7'b1111111;
        w_dp_nxt   = 1'b1;
        w_an_nxt   = '1;
        w_tick_nxt = 1'b0;
        if (en && (r_state == c_st_show)) begin
            w_dp_nxt = ~r_dp_reg[r_idx];
            if (w_suppress) begin
                // Segments stay dark; the anode only turns on to light the point
                if (r_dp_reg[r_idx]) begin
                    w_an_nxt = ~w_onehot;
                end
            end else begin
                w_an_nxt  = ~w_onehot;
                w_seg_nxt = f_decode(r_digit[r_idx]);
            end
            w_tick_nxt = (r_idx == c_idx_last) && (r_cnt == c_cnt_last);
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            an         <= '1;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg        <= w_seg_nxt;
            dp         <= w_dp_nxt;
            an         <= w_an_nxt;
            digit_idx  <= r_idx;
            frame_tick <= w_tick_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Directed testbench for seg7_scan_ctrl with AW=2, PRESCALE=8,
//            BLANK=2. Every cycle the pins are compared against
//            hand-computed values; slot layout is 2 dark + 6 lit cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int AW       = 2;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit c_lzb = 1'b1;
`else
    localparam bit c_lzb = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] digit_idx;
    logic       frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    // Expected pin values per digit while it is lit
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];

    seg7_scan_ctrl #(
        .AW       (AW),
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {frame_tick, digit_idx, an, seg, dp}
    function automatic logic [14:0] ex(input logic ft, input logic [1:0] di,
                                       input logic [3:0] a, input logic [6:0] s,
                                       input logic d);
        return {ft, di, a, s, d};
    endfunction

    function automatic logic [14:0] dark(input logic [1:0] di);
        return {1'b0, di, 4'b1111, 7'b1111111, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [14:0] exp);
        logic [14:0] obs;
        obs = {frame_tick, digit_idx, an, seg, dp};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed ft/idx/an/seg/dp=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic cyc(input string tag, input logic [14:0] exp);
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    // One full slot for digit d: 2 dark cycles then 6 lit cycles
    task automatic slot(input int d);
        for (int c = 0; c < 8; c++) begin
            if (c < 2)
                cyc($sformatf("slot%0d_dark%0d", d, c), dark(2'(d)));
            else
                cyc($sformatf("slot%0d_lit%0d", d, c),
                    ex((c == 7) && (d == 3), 2'(d), exp_an[d], exp_seg[d], exp_dp[d]));
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] v, input logic p);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = v;
        wr_dp   = p;
    endtask

    initial begin
        // Reset held 3 cycles with en and a write request both active
        rst = 1'b1; en = 1'b1;
        wr(2'd1, 4'h9, 1'b1);
        for (int i = 0; i < 3; i++) cyc("reset", dark(2'd0));

        // Load 3, 0, A, F with the point on digit 2 while the scan is off
        rst = 1'b0; en = 1'b0;
        wr(2'd0, 4'h3, 1'b0); cyc("load0", dark(2'd0));
        wr(2'd1, 4'h0, 1'b0); cyc("load1", dark(2'd0));
        wr(2'd2, 4'hA, 1'b1); cyc("load2", dark(2'd0));
        wr(2'd3, 4'hF, 1'b0); cyc("load3", dark(2'd0));
        wr_en = 1'b0;

        exp_an[0] = 4'b1110; exp_seg[0] = 7'b0000110; exp_dp[0] = 1'b1;
        exp_an[1] = 4'b1101; exp_seg[1] = 7'b0000001; exp_dp[1] = 1'b1;
        exp_an[2] = 4'b1011; exp_seg[2] = 7'b0001000; exp_dp[2] = 1'b0;
        exp_an[3] = 4'b0111; exp_seg[3] = 7'b0111000; exp_dp[3] = 1'b1;

        // Enable: one IDLE cycle, then two full frames
        en = 1'b1;
        cyc("start", dark(2'd0));
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 4; d++) slot(d);

        // Live update of digit 1 while it is lit
        slot(0);
        cyc("live_dark0", dark(2'd1));
        cyc("live_dark1", dark(2'd1));
        cyc("live_old0", ex(1'b0, 2'd1, 4'b1101, 7'b0000001, 1'b1));
        wr(2'd1, 4'h7, 1'b0);
        cyc("live_old1", ex(1'b0, 2'd1, 4'b1101, 7'b0000001, 1'b1));
        wr_en = 1'b0;
        exp_seg[1] = 7'b0001111;
        for (int c = 4; c < 8; c++)
            cyc($sformatf("live_new%0d", c), ex(1'b0, 2'd1, 4'b1101, 7'b0001111, 1'b1));
        slot(2);
        slot(3);

        // Enable drop in the middle of digit 2's lit phase
        slot(0);
        slot(1);
        cyc("drop_dark0", dark(2'd2));
        cyc("drop_dark1", dark(2'd2));
        cyc("drop_lit0", ex(1'b0, 2'd2, 4'b1011, 7'b0001000, 1'b0));
        cyc("drop_lit1", ex(1'b0, 2'd2, 4'b1011, 7'b0001000, 1'b0));
        en = 1'b0;
        cyc("drop_off0", dark(2'd2));
        cyc("drop_off1", dark(2'd0));
        en = 1'b1;
        cyc("restart", dark(2'd0));
        slot(0);
        slot(1);
        slot(2);

        // Reset in the middle of digit 3's lit phase, with a competing write
        cyc("mrst_dark0", dark(2'd3));
        cyc("mrst_dark1", dark(2'd3));
        cyc("mrst_lit0", ex(1'b0, 2'd3, 4'b0111, 7'b0111000, 1'b1));
        cyc("mrst_lit1", ex(1'b0, 2'd3, 4'b0111, 7'b0111000, 1'b1));
        rst = 1'b1;
        wr(2'd1, 4'h9, 1'b1);
        cyc("mrst_edge", dark(2'd0));
        rst = 1'b0;
        wr_en = 1'b0;
        cyc("mrst_idle", dark(2'd0));

        // All digits now 0 with no points lit
        exp_an[0] = 4'b1110; exp_seg[0] = 7'b0000001; exp_dp[0] = 1'b1;
        exp_an[1] = c_lzb ? 4'b1111 : 4'b1101;
        exp_seg[1] = c_lzb ? 7'b1111111 : 7'b0000001; exp_dp[1] = 1'b1;
        exp_an[2] = c_lzb ? 4'b1111 : 4'b1011;
        exp_seg[2] = c_lzb ? 7'b1111111 : 7'b0000001; exp_dp[2] = 1'b1;
        exp_an[3] = c_lzb ? 4'b1111 : 4'b0111;
        exp_seg[3] = c_lzb ? 7'b1111111 : 7'b0000001; exp_dp[3] = 1'b1;
        for (int d = 0; d < 4; d++) slot(d);

        // Digits 3..0 = 0, 0(point on), 5, 0
        en = 1'b0;
        wr(2'd1, 4'h5, 1'b0); cyc("lz_load0", dark(2'd0));
        wr(2'd2, 4'h0, 1'b1); cyc("lz_load1", dark(2'd0));
        wr_en = 1'b0; en = 1'b1;
        cyc("lz_start", dark(2'd0));
        exp_an[1] = 4'b1101; exp_seg[1] = 7'b0100100; exp_dp[1] = 1'b1;
        exp_an[2] = 4'b1011; exp_seg[2] = c_lzb ? 7'b1111111 : 7'b0000001; exp_dp[2] = 1'b0;
        for (int d = 0; d < 4; d++) slot(d);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed controller for an NDIG-digit common-anode seven-segment display.
- Holds one 4-bit hex value and one decimal-point bit per digit in an internal register file, and scans digits round-robin.
- Shares a single hex-to-segment decode path across all digits.
- Sits between the datapath, which writes digit values, and the board display pins.

Parameters:
- AW, 2, digit address width; NDIG = 2**AW digits.
- PRESCALE, 50000, clock cycles per digit slot; must be > BLANK.
- BLANK, 16, anti-ghosting cycles at the start of each slot with everything off; 0 disables blanking.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 = display dark.
- wr_en  in  1  digit write strobe.
- wr_addr  in  AW  digit index; 0 = least significant (rightmost).
- wr_data  in  4  hex value.
- wr_dp  in  1  decimal point for that digit; 1 = lit.
- seg  out  7  active-low segments; seg[6]=a … seg[0]=g.
- dp  out  1  active-low decimal point.
- an  out  NDIG  active-low anode enables, one-hot-low.
- digit_idx  out  AW  index of the slot being scanned.
- frame_tick  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Every output is a register.

Reset (rst=1 at an edge):
- Digit register file cleared to 0 with dp=0; cnt=0, idx=0, state=IDLE.
- Outputs: seg=7'b1111111, dp=1, an=all 1, digit_idx=0, frame_tick=0.
- rst has priority over wr_en and en in the same cycle, including mid-frame.

Segment encoding, per hex value (bits a..g, active low):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110
- 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, b=1100000
- C=0110001, d=1000010, E=0110000, F=0111000

State machine (states IDLE, BLANK, SHOW):
- IDLE: outputs dark. If en=1, go to BLANK with cnt=0, idx=0; if BLANK=0, go directly to SHOW.
- BLANK: an all 1, seg all 1, dp=1. cnt increments; at cnt==BLANK-1, go to SHOW.
- SHOW: an[idx]=0 and the rest 1; seg=decode(digit[idx]); dp=~dp_reg[idx].
  - At cnt==PRESCALE-1: cnt=0, idx wraps with idx+1 mod NDIG, next state is BLANK (or SHOW if BLANK=0).
- en=0 in any state: next edge goes to IDLE, cnt=0, idx=0, outputs dark.

Timing:
- Outputs lag the state by exactly one cycle.
- After rst release with en=1: BLANK+1 dark cycles, then digit 0 for PRESCALE-BLANK cycles, then the next slot.
- Slot period is exactly PRESCALE cycles; frame period is NDIG*PRESCALE.
- digit_idx follows idx, also registered with one-cycle lag.

frame_tick:
- 1 for exactly one cycle, the cycle after the edge where idx==NDIG-1 and cnt==PRESCALE-1.
- Never asserted in IDLE.

Writes:
- Accepted on any edge with wr_en=1, regardless of scan state; no backpressure.
- A write to the digit currently in SHOW appears on seg/dp two edges after the write edge: capture, then output register.
- Writes to other digits appear at that digit's next SHOW.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: any digit k>0 whose value is 0 and whose more-significant digits are all 0 is shown dark during its SHOW.
  - seg=1111111 and an stays 1 for that slot.
  - dp still follows dp_reg[k]; if dp_reg[k]=1, an[k] is driven 0 so the point lights.
  - Digit 0 is never suppressed.
- Undefined: all digits are always displayed. Slot timing and frame_tick are identical in both builds.

Test Plan (AW=2, PRESCALE=8, BLANK=2):
- Reset: hold rst=1 for 3 cycles with en=1 and wr_en=1 → seg=1111111, dp=1, an=1111, frame_tick=0; register file stays 0.
- Scan: write addr0..3 with 3, 0, A, F (dp=1 on addr2), then en=1.
  - 3 dark cycles, then an=1110 seg=0000110 for 6 cycles.
  - Then 2 dark cycles, then an=1101 seg=0000001.
  - Then an=1011 seg=0001000 dp=0.
  - Then an=0111 seg=0111000.
  - frame_tick pulses once, then the pattern repeats with a 32-cycle period.
- Live update: during SHOW of addr1, write addr1=7 → seg becomes 0001111 exactly 2 edges later; an is unchanged.
- Enable drop: deassert en mid-SHOW of addr2 → an=1111 on the next cycle. Re-assert → restarts at addr0 with a BLANK phase.
- Reset mid-frame: assert rst during SHOW of addr3 → next cycle dark; register file reads 0; scan resumes from addr0.
- Macro defined: addr3..0 = 0, 0, 5, 0 → addr3 and addr2 slots dark (an=1111), addr1 seg=0100100, addr0 seg=0000001.
